// File: rtl/dot_accum_requant.sv
// dot_accum_requant: accumulates TILES unsigned partial sums into a signed
// accumulator, adds a programmable bias, rounds, shifts right by SHIFT and
// saturates the result to one output byte held under a valid/ready handshake.
//
// Optional feature macro: ACT_RELU_EN
//   undefined -> signed saturation to [-128, 127], two's-complement out_data
//   defined   -> ReLU clamp to [0, 255], unsigned out_data
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   synchronous active-low reset
//   in_valid   in   1   partial sum present
//   in_ready   out  1   partial sum accepted this cycle (ACCUM only)
//   in_psum    in   18  unsigned partial sum
//   bias_load  in   1   write bias_in into the bias register
//   bias_in    in   16  signed bias
//   out_valid  out  1   out_data holds a result
//   out_ready  in   1   downstream accepts out_data
//   out_data   out  8   requantized result
//   tile_cnt   out  6   partial sums accepted in the current batch
module dot_accum_requant #(
  parameter int unsigned TILES = 4,
  parameter int unsigned SHIFT = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_psum,
  input  logic        bias_load,
  input  logic [15:0] bias_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [5:0]  tile_cnt
);

  localparam int unsigned PSUM_W = 18;
  localparam int unsigned BIAS_W = 16;
  localparam int unsigned ACC_W  = 26;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned CNT_W  = 6;
  // Wide enough for acc + bias + rounding constant without wrap.
  localparam int unsigned SUM_W  = 28;

  localparam logic [CNT_W-1:0]        LAST_TILE = CNT_W'(TILES - 1);
  localparam logic signed [SUM_W-1:0] RND       = SUM_W'(1 << (SHIFT - 1));
`ifdef ACT_RELU_EN
  localparam logic signed [SUM_W-1:0] SAT_HI    = SUM_W'(255);
  localparam logic signed [SUM_W-1:0] SAT_LO    = SUM_W'(0);
`else
  localparam logic signed [SUM_W-1:0] SAT_HI    = SUM_W'(127);
  localparam logic signed [SUM_W-1:0] SAT_LO    = SUM_W'(-128);
`endif

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    REQUANT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [BIAS_W-1:0]  bias_q, bias_d;
  logic [CNT_W-1:0]          tile_cnt_q, tile_cnt_d;
  logic [OUT_W-1:0]          out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      in_ready_q, in_ready_d;

  logic signed [SUM_W-1:0]   sum_c;
  logic signed [SUM_W-1:0]   shr_c;
  logic [OUT_W-1:0]          sat_c;

  // Rounded, shifted and clamped result of the current accumulator and bias.
  always_comb begin
    sum_c = SUM_W'(acc_q) + SUM_W'(bias_q) + RND;
    shr_c = sum_c >>> SHIFT;
    if (shr_c > SAT_HI) begin
      sat_c = SAT_HI[OUT_W-1:0];
    end else if (shr_c < SAT_LO) begin
      sat_c = SAT_LO[OUT_W-1:0];
    end else begin
      sat_c = shr_c[OUT_W-1:0];
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    tile_cnt_d = tile_cnt_q;
    out_data_d = out_data_q;
    // The REQUANT cycle reads bias_q, so a load there only affects the next batch.
    bias_d     = bias_load ? $signed(bias_in) : bias_q;

    unique case (state_q)
      ACCUM: begin
        if (in_valid && in_ready_q) begin
          acc_d = acc_q + $signed(ACC_W'(in_psum));
          if (tile_cnt_q == LAST_TILE) begin
            tile_cnt_d = '0;
            state_d    = REQUANT;
          end else begin
            tile_cnt_d = tile_cnt_q + CNT_W'(1);
          end
        end
      end
      REQUANT: begin
        out_data_d = sat_c;
        acc_d      = '0;
        state_d    = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase

    // Handshake flags are registered copies of the next-state decode.
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == HOLD);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      bias_q      <= '0;
      tile_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      bias_q      <= bias_d;
      tile_cnt_q  <= tile_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign tile_cnt  = tile_cnt_q;

  // PSUM_W documents the input width used in the accumulate cast above.
  if (PSUM_W != 18) begin : g_psum_w_check
    $error("in_psum width mismatch");
  end

endmodule

// File: tb/tb_dot_accum_requant.sv
// Scoreboard bench for dot_accum_requant (TILES=4, SHIFT=6). Expected bytes
// are queued as each batch is issued; a monitor pops one per output handshake.
module tb_dot_accum_requant;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_psum;
  logic        bias_load;
  logic [15:0] bias_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [5:0]  tile_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

`ifdef ACT_RELU_EN
  localparam logic [7:0] EXP_SAT = 8'hFF;
  localparam logic [7:0] EXP_NEG = 8'h00;
`else
  localparam logic [7:0] EXP_SAT = 8'h7F;
  localparam logic [7:0] EXP_NEG = 8'hF0;
`endif

  dot_accum_requant #(.TILES(4), .SHIFT(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_psum   (in_psum),
    .bias_load (bias_load),
    .bias_in   (bias_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .tile_cnt  (tile_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: compare every output handshake against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got 0x%0h, expected no output", out_data);
      end else begin
        check("out_data", int'(out_data), int'(exp_q.pop_front()));
      end
    end
  end

  // Present one psum and hold it until accepted (bounded wait).
  task automatic send_psum(input logic [17:0] v);
    int n;
    in_valid = 1'b1;
    in_psum  = v;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready=0, expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_batch(input logic [17:0] a, input logic [17:0] b,
                            input logic [17:0] c, input logic [17:0] d,
                            input logic [7:0] exp);
    exp_q.push_back(exp);
    send_psum(a);
    send_psum(b);
    send_psum(c);
    send_psum(d);
  endtask

  task automatic load_bias(input logic [15:0] v);
    bias_load = 1'b1;
    bias_in   = v;
    @(posedge clk);
    #1;
    bias_load = 1'b0;
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_psum   = '0;
    bias_load = 1'b0;
    bias_in   = '0;
    out_ready = 1'b1;

    // Reset for two cycles.
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_data", int'(out_data), 8'h00);
    check("rst_tile_cnt", int'(tile_cnt), 0);
    @(posedge clk);
    #1;

    // Basic batch with latency and post-handshake checks.
    exp_q.push_back(8'h10);
    send_psum(18'd100);
    send_psum(18'd200);
    @(negedge clk);
    check("tile_cnt_mid", int'(tile_cnt), 2);
    @(posedge clk);
    #1;
    send_psum(18'd300);
    send_psum(18'd400);
    @(negedge clk);
    check("lat_requant_valid", int'(out_valid), 0);
    check("lat_requant_ready", int'(in_ready), 0);
    check("lat_tile_cnt_clr", int'(tile_cnt), 0);
    @(negedge clk);
    check("lat_hold_valid", int'(out_valid), 1);
    @(posedge clk);
    #1;
    check("post_hs_valid", int'(out_valid), 0);
    check("post_hs_data", int'(out_data), 8'h10);
    check("post_hs_ready", int'(in_ready), 1);

    // Saturation.
    send_batch(18'd65025, 18'd65025, 18'd65025, 18'd65025, EXP_SAT);

    // Negative bias.
    load_bias(16'hF830);  // -2000
    send_batch(18'd100, 18'd200, 18'd300, 18'd400, EXP_NEG);

    // Bias load during REQUANT: old bias (-2000) applies, new (0) next batch.
    send_batch(18'd100, 18'd200, 18'd300, 18'd400, EXP_NEG);
    load_bias(16'h0000);
    send_batch(18'd100, 18'd200, 18'd300, 18'd400, 8'h10);

    // Backpressure in HOLD with a psum waiting upstream.
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    out_ready = 1'b0;
    send_batch(18'd100, 18'd200, 18'd300, 18'd400, 8'h10);
    @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_psum  = 18'd1000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_data", int'(out_data), 8'h10);
      check("bp_tile_cnt", int'(tile_cnt), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_batch(18'd1000, 18'd1000, 18'd1000, 18'd1000, 8'h3F);

    // Mid-batch reset discards partial sums.
    send_psum(18'd5000);
    send_psum(18'd5000);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_tile_cnt", int'(tile_cnt), 0);
    @(posedge clk);
    #1;
    send_batch(18'd1000, 18'd1000, 18'd1000, 18'd1000, 8'h3F);

    // Drain remaining expected outputs.
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
